mixer_sequencer: RTL and testbench



---
 rtl/mixer_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mixer_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mixer_sequencer                                                 |
// | Purpose  : Time-shares one two-input mixer between N_REQ requesters.       |
// |            Grants ownership round-robin, then steps the valve/pump         |
// |            controls through load-A, load-B, mix and flush phases and       |
// |            pulses done to the owner. abort cuts an operation short but     |
// |            always drains the chamber through FLUSH.                        |
// | Ports    : clk, rst_n        clock, asynchronous active-low reset          |
// |            req[N_REQ]        level requests                                |
// |            mix_len           per-requester mix length, CNT_W bits each     |
// |            abort             end current operation early (via FLUSH)       |
// |            grant[N_REQ]      one-hot owner of the mixer                    |
// |            busy              sequence in progress                          |
// |            valve_a/valve_b   inlet valves                                  |
// |            pump_en           mixing pump                                   |
// |            valve_out         outlet (drain) valve                          |
// |            done[N_REQ]       one-cycle completion pulse to the owner       |
// |            aborted           qualifies done: operation was aborted         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mixer_sequencer #(
   parameter int N_REQ        = 4,
   parameter int CNT_W        = 8,
   parameter int LOAD_CYCLES  = 4,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*CNT_W-1:0]   mix_len,
   input  logic                     abort,
   output logic [N_REQ-1:0]         grant,
   output logic                     busy,
   output logic                     valve_a,
   output logic                     valve_b,
   output logic                     pump_en,
   output logic                     valve_out,
   output logic [N_REQ-1:0]         done,
   output logic                     aborted
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      MIX    = 3'd3,
      FLUSH  = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [CNT_W-1:0]   len, len_nx;
   logic [IDX_W-1:0]   ptr, ptr_nx;
   logic               ab_flag, ab_flag_nx;
   logic [N_REQ-1:0]   grant_nx;

   // ---------------------------------------------------------------
   // Round-robin search: first set req bit at or above ptr, wrapping.
   // ---------------------------------------------------------------
   logic [IDX_W:0]     pos;
   logic               found;
   logic [IDX_W-1:0]   sel;
   logic [CNT_W-1:0]   sel_len;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      pos   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(N_REQ)) begin
            pos = pos - (IDX_W+1)'(N_REQ);
         end
         if (!found && req[pos[IDX_W-1:0]]) begin
            found = 1'b1;
            sel   = pos[IDX_W-1:0];
         end
      end
   end

   assign sel_len = mix_len[sel*CNT_W +: CNT_W];

   // ---------------------------------------------------------------
   // Next-state logic. Each phase counter is loaded with (length-1) on
   // entry and the phase ends on the cycle it reads 0.
   // ---------------------------------------------------------------
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      len_nx     = len;
      ptr_nx     = ptr;
      ab_flag_nx = ab_flag;
      grant_nx   = grant;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (found) begin
               state_nx   = LOAD_A;
               cnt_nx     = CNT_W'(LOAD_CYCLES - 1);
               grant_nx   = N_REQ'(1) << sel;
               // a zero mix length still runs the pump for one cycle
               len_nx     = (sel_len == '0) ? CNT_W'(1) : sel_len;
               ptr_nx     = (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
               ab_flag_nx = 1'b0;
            end
         end
         LOAD_A: begin
            if (abort) begin
               state_nx   = FLUSH;
               cnt_nx     = CNT_W'(FLUSH_CYCLES - 1);
               ab_flag_nx = 1'b1;
            end else if (cnt == '0) begin
               state_nx = LOAD_B;
               cnt_nx   = CNT_W'(LOAD_CYCLES - 1);
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         LOAD_B: begin
            if (abort) begin
               state_nx   = FLUSH;
               cnt_nx     = CNT_W'(FLUSH_CYCLES - 1);
               ab_flag_nx = 1'b1;
            end else if (cnt == '0) begin
               state_nx = MIX;
               cnt_nx   = len - 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         MIX: begin
            if (abort) begin
               state_nx   = FLUSH;
               cnt_nx     = CNT_W'(FLUSH_CYCLES - 1);
               ab_flag_nx = 1'b1;
            end else if (cnt == '0) begin
               state_nx = FLUSH;
               cnt_nx   = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         FLUSH: begin
            if (cnt == '0) begin
               state_nx = DONE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         DONE: begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            grant_nx   = '0;
            ab_flag_nx = 1'b0;
         end
         default: begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            grant_nx   = '0;
            ab_flag_nx = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // State and output registers. Outputs are decoded from the next
   // state so that each registered output lines up with the state
   // register, with no combinational path to the valve driver.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         len       <= '0;
         ptr       <= '0;
         ab_flag   <= 1'b0;
         grant     <= '0;
         busy      <= 1'b0;
         valve_a   <= 1'b0;
         valve_b   <= 1'b0;
         pump_en   <= 1'b0;
         valve_out <= 1'b0;
         done      <= '0;
         aborted   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         len       <= len_nx;
         ptr       <= ptr_nx;
         ab_flag   <= ab_flag_nx;
         grant     <= grant_nx;
         busy      <= (state_nx != IDLE);
         valve_a   <= (state_nx == LOAD_A);
         valve_b   <= (state_nx == LOAD_B);
         pump_en   <= (state_nx == MIX);
         valve_out <= (state_nx == FLUSH);
         done      <= (state_nx == DONE) ? grant_nx : '0;
         aborted   <= (state_nx == DONE) && ab_flag_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mixer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mixer_sequencer                                              |
// | Purpose  : Self-checking bench for mixer_sequencer (N_REQ=4, LOAD=2,       |
// |            FLUSH=2). A transaction-level model predicts every output       |
// |            from each operation's start cycle, mix length and flush start.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mixer_sequencer;

   localparam int N     = 4;
   localparam int CW    = 8;
   localparam int LOADC = 2;
   localparam int FLC   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req = '0;
   logic [N*CW-1:0]   mix_len = '0;
   logic              abort = 1'b0;
   logic [N-1:0]      grant;
   logic              busy, valve_a, valve_b, pump_en, valve_out, aborted;
   logic [N-1:0]      done;

   mixer_sequencer #(
      .N_REQ(N), .CNT_W(CW), .LOAD_CYCLES(LOADC), .FLUSH_CYCLES(FLC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mix_len(mix_len), .abort(abort),
      .grant(grant), .busy(busy), .valve_a(valve_a), .valve_b(valve_b),
      .pump_en(pump_en), .valve_out(valve_out), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   logic [13:0] outs;
   assign outs = {grant, busy, valve_a, valve_b, pump_en, valve_out, done, aborted};

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // model of the operation in flight
   bit m_active = 0;
   int m_own, m_s, m_fs, m_ptr = 0;
   bit m_ab;

   // grant/done scoreboard
   int          own_q[$];
   logic [N-1:0] prev_grant = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 1 LOAD_A, 2 LOAD_B, 3 MIX, 4 FLUSH, 5 DONE for cycle k of the active op
   function automatic int phase(int k);
      if (k >= m_fs + FLC) return 5;
      if (k >= m_fs)       return 4;
      if (k < m_s + LOADC) return 1;
      if (k < m_s + 2*LOADC) return 2;
      return 3;
   endfunction

   function automatic logic [13:0] exp_vec(int k);
      logic [N-1:0] g;
      int ph;
      if (!m_active) return '0;
      g  = N'(1) << m_own;
      ph = phase(k);
      return {g, 1'b1, ph == 1, ph == 2, ph == 3, ph == 4,
              (ph == 5) ? g : 4'b0, (ph == 5) && m_ab};
   endfunction

   task automatic model_advance();
      int ph, idx, l;
      if (!m_active) begin
         if (req != '0) begin
            idx = -1;
            for (int k = 0; k < N; k++) begin
               if (idx < 0 && req[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
            end
            l = int'(mix_len[idx*CW +: CW]);
            if (l == 0) l = 1;
            m_active = 1;
            m_own    = idx;
            m_s      = cyc + 1;
            m_fs     = m_s + 2*LOADC + l;
            m_ab     = 0;
            m_ptr    = (idx + 1) % N;
         end
      end else begin
         ph = phase(cyc);
         if (ph >= 1 && ph <= 3 && abort) begin
            m_fs = cyc + 1;
            m_ab = 1;
         end else if (ph == 5) begin
            m_active = 0;
         end
      end
   endtask

   // advance one clock, then check every output against the model
   task automatic step();
      if (!rst_n) begin
         m_active = 0;
         m_ptr    = 0;
         own_q.delete();
      end else begin
         model_advance();
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("outputs", 32'(outs), 32'(exp_vec(cyc)));
      chk("valve_onehot0", 32'($onehot0({valve_a, valve_b, pump_en, valve_out})), 32'd1);
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (grant != '0 && prev_grant == '0) begin
         for (int i = 0; i < N; i++) if (grant[i]) own_q.push_back(i);
      end
      if (done != '0) begin
         if (own_q.size() == 0) begin
            chk("done_without_grant", 32'(done), 32'd0);
         end else begin
            chk("done_owner", 32'(done), 32'(N'(1) << own_q.pop_front()));
         end
      end
      prev_grant = grant;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) step();
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   int pumps, seen, gap_ok;
   logic [N-1:0] gseq[$];
   int           gcyc[$];
   logic [N-1:0] gexp[5];

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      chk("reset_outputs", 32'(outs), 32'd0);

      // ---------------- basic op, mix_len=5 ----------------
      req = 4'b0001;
      mix_len = 32'h0000_0005;
      step();
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_valve_a", 32'(valve_a), 32'd1);
      req = '0;
      pumps = 0;
      for (int i = 2; i <= 12; i++) begin
         step();
         pumps += int'(pump_en);
         if (i < 12) chk("t1_no_early_done", 32'(done), 32'd0);
      end
      chk("t1_done", 32'({done, aborted}), 32'({4'b0001, 1'b0}));
      chk("t1_pump_cycles", 32'(pumps), 32'd5);
      step();
      chk("t1_back_idle", 32'(busy), 32'd0);

      // ---------------- round robin, all requesting ----------------
      do_reset();
      mix_len = 32'h0101_0101;
      req = 4'b1111;
      for (int i = 0; i < 100 && gseq.size() < 5; i++) begin
         step();
         if (grant != '0 && gseq.size() < 5 &&
             (gseq.size() == 0 || gcyc[gcyc.size()-1] != -1) &&
             (busy && valve_a && (gcyc.size() == 0 || cyc - gcyc[gcyc.size()-1] > 1))) begin
            gseq.push_back(grant);
            gcyc.push_back(cyc);
         end
      end
      req = '0;
      chk("rr_count", 32'(gseq.size()), 32'd5);
      gexp[0] = 4'b0001; gexp[1] = 4'b0010; gexp[2] = 4'b0100;
      gexp[3] = 4'b1000; gexp[4] = 4'b0001;
      for (int i = 0; i < 5 && i < gseq.size(); i++) chk("rr_order", 32'(gseq[i]), 32'(gexp[i]));
      // LOAD 2+2, MIX 1, FLUSH 2, DONE 1, IDLE 1
      for (int i = 1; i < gcyc.size(); i++) chk("rr_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd9);
      wait_idle();

      // ---------------- mix_len = 0 runs MIX for one cycle ----------------
      req = 4'b0100;
      mix_len = 32'h0;
      step();
      chk("t3_grant", 32'(grant), 32'h4);
      req = '0;
      pumps = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         pumps += int'(pump_en);
         if (done != '0) seen = 1;
      end
      chk("t3_done_seen", 32'(seen), 32'd1);
      chk("t3_pump_cycles", 32'(pumps), 32'd1);
      wait_idle();

      // ---------------- abort on 3rd MIX cycle ----------------
      req = 4'b0001;
      mix_len = 32'h0000_000A;
      step();
      req = '0;
      pumps = 0;
      for (int i = 0; i < 40 && pumps < 3; i++) begin
         step();
         pumps += int'(pump_en);
      end
      chk("t4_reached_mix3", 32'(pumps), 32'd3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_pump_off", 32'(pump_en), 32'd0);
      chk("t4_flush1", 32'(valve_out), 32'd1);
      step();
      chk("t4_flush2", 32'(valve_out), 32'd1);
      step();
      chk("t4_done_aborted", 32'({done, aborted}), 32'({4'b0001, 1'b1}));
      step();
      req = 4'b0001;
      mix_len = 32'h0000_0001;
      step();
      req = '0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (done != '0) seen = 1;
      end
      chk("t4_next_done_seen", 32'(seen), 32'd1);
      chk("t4_next_not_aborted", 32'(aborted), 32'd0);
      wait_idle();

      // ---------------- async reset during LOAD_B ----------------
      req = 4'b0001;   // leaves the pointer at 1 if reset fails to clear it
      mix_len = 32'h0000_0003;
      step();
      req = '0;
      for (int i = 0; i < 20 && !valve_b; i++) step();
      chk("t5_in_load_b", 32'(valve_b), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_async_clear", 32'(outs), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      req = 4'b0011;
      step();
      chk("t5_ptr_reset", 32'(grant), 32'h1);
      req = '0;
      wait_idle();
      req = 4'b0010;
      wait_idle();
      step();
      chk("t5_req1_grant", 32'(grant), 32'h2);
      req = '0;
      wait_idle();

      // ---------------- random run ----------------
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         for (int j = 0; j < N; j++) mix_len[j*CW +: CW] = 8'($urandom_range(0, 7));
         abort = ($urandom_range(0, 19) == 0);
         step();
      end
      req = '0;
      abort = 1'b0;
      wait_idle();
      step();
      chk("rand_all_done", 32'(own_q.size()), 32'd0);

      gap_ok = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
